// File: rtl/whr_arb_pkg.sv
// Shared types and constants for the wormhole router switch arbiters.
// Holds the arbiter state, the error capture modes and the error vector layout.
package whr_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Same encoding as the router's error reporter.
  typedef enum logic [1:0] {
    ERROR_CAPTURE_MODE_NONE    = 2'd0,
    ERROR_CAPTURE_MODE_NO_HOLD = 2'd1,
    ERROR_CAPTURE_MODE_HOLD    = 2'd2
  } error_capture_mode_e;

  localparam int ERR_HEAD_IN_PKT  = 0;
  localparam int ERR_BODY_IN_IDLE = 1;
  localparam int ERR_UTURN        = 2;
  localparam int ERR_NUM          = 3;

  // Index width for n items; never narrower than one bit.
  function automatic int clogb(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int num_ports_default = 5;
  localparam int port_idx_width    = clogb(num_ports_default);

endpackage

// File: rtl/whr_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after
// ptr (wrapping) wins; gnt is one-hot, idx is its encoded position.
module whr_rr_pick
  import whr_arb_pkg::*;
#(
  parameter int num_ports = 5,
  parameter int idx_width = clogb(num_ports)
) (
  input  logic [num_ports-1:0] req,
  input  logic [idx_width-1:0] ptr,
  output logic [num_ports-1:0] gnt,
  output logic [idx_width-1:0] idx,
  output logic                 valid
);

  logic [idx_width-1:0] pos;

  // NOTE: every output is given a default before the loop so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < num_ports; k++) begin
      pos = idx_width'((int'(ptr) + k) % num_ports);
      if (!valid && req[pos]) begin
        valid    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/whr_op_arb_ctrl.sv
// Per-output-port switch arbiter: round-robin over head requests, then holds
// the grant on one input from head to tail so packets never interleave.
module whr_op_arb_ctrl
  import whr_arb_pkg::*;
#(
  parameter int                  num_ports          = 5,
  parameter int                  flit_data_width    = 64,
  parameter int                  port_id            = 0,
  parameter error_capture_mode_e error_capture_mode = ERROR_CAPTURE_MODE_NO_HOLD,
  localparam int                 idx_width          = clogb(num_ports)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [num_ports-1:0]                 req_ip,
  input  logic [num_ports-1:0]                 req_head_ip,
  input  logic [num_ports-1:0]                 req_tail_ip,
  input  logic [num_ports*flit_data_width-1:0] flit_data_ip,
  input  logic                                 elig,
  input  logic                                 full,
  output logic [num_ports-1:0]                 gnt_ip,
  output logic                                 flit_valid_out,
  output logic                                 flit_head_out,
  output logic                                 flit_tail_out,
  output logic [flit_data_width-1:0]           flit_data_out,
  output logic                                 locked,
  output logic [idx_width-1:0]                 owner,
  output logic                                 error
);

  typedef logic [idx_width-1:0] idx_t;

  arb_state_e state_q, state_d;
  idx_t       owner_q, owner_d;
  idx_t       rr_ptr_q, rr_ptr_d;
  logic       err_q, err_d;

  logic [num_ports-1:0]       cand;
  logic [num_ports-1:0]       pick_gnt;
  idx_t                       pick_idx;
  logic                       pick_valid;
  logic [num_ports-1:0]       gnt;
  idx_t                       sel;
  logic                       any_gnt;
  logic [ERR_NUM-1:0]         err_cond;
  logic [flit_data_width-1:0] port_data [num_ports];

  // Port 0 occupies the most significant slice of the flattened data bus.
  always_comb begin
    for (int i = 0; i < num_ports; i++) begin
      port_data[i] = flit_data_ip[(num_ports-1-i)*flit_data_width +: flit_data_width];
    end
  end

  // A new packet may only start when the controller is free and has credit.
  assign cand = (elig && !full) ? (req_ip & req_head_ip) : '0;

  whr_rr_pick #(
    .num_ports (num_ports),
    .idx_width (idx_width)
  ) u_rr_pick (
    .req   (cand),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt      = '0;
    sel      = owner_q;
    unique case (state_q)
      ARB_IDLE: begin
        sel = pick_idx;
        if (pick_valid) begin
          gnt      = pick_gnt;
          rr_ptr_d = (pick_idx == idx_t'(num_ports-1)) ? '0 : pick_idx + idx_t'(1);
          if (!req_tail_ip[pick_idx]) begin
            state_d = ARB_LOCKED;
            owner_d = pick_idx;
          end
        end
      end
      ARB_LOCKED: begin
        if (req_ip[owner_q] && !full) begin
          gnt[owner_q] = 1'b1;
          if (req_tail_ip[owner_q]) begin
            state_d = ARB_IDLE;
          end
        end
      end
    endcase
    // Grants are suppressed for the whole reset assertion, not just at the edge.
    if (!reset) begin
      gnt = '0;
    end
  end

  assign any_gnt        = |gnt;
  assign gnt_ip         = gnt;
  assign flit_valid_out = any_gnt;
  assign flit_head_out  = any_gnt & req_head_ip[sel];
  assign flit_tail_out  = any_gnt & req_tail_ip[sel];
  assign flit_data_out  = any_gnt ? port_data[sel] : '0;

  always_comb begin
    err_cond                   = '0;
    err_cond[ERR_HEAD_IN_PKT]  = (state_q == ARB_LOCKED) && req_ip[owner_q] && req_head_ip[owner_q];
    err_cond[ERR_BODY_IN_IDLE] = (state_q == ARB_IDLE) && |(req_ip & ~req_head_ip);
    if (port_id < num_ports) begin
      err_cond[ERR_UTURN] = req_ip[port_id];
    end
  end

  always_comb begin
    err_d = 1'b0;
    unique case (error_capture_mode)
      ERROR_CAPTURE_MODE_NO_HOLD: err_d = |err_cond;
      ERROR_CAPTURE_MODE_HOLD:    err_d = err_q | (|err_cond);
      default:                    err_d = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign locked = (state_q == ARB_LOCKED);
  assign owner  = owner_q;
  assign error  = err_q;

endmodule
